// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/sequence stage feeding the 3-to-8 ALU op decoder.
// Fetches 8-bit instruction words over a req/valid handshake, holds them in an
// instruction register and steps IDLE -> FETCH -> DECODE -> EXEC -> WB.
// Instruction word: [7:5] op, [4] halt (only when op=000), [3:2] rd, [1:0] rs.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        leave IDLE/HALT and begin fetching
//   imem_req     fetch request, imem_addr = pc while requesting (else 0)
//   imem_valid   imem_data valid; only sampled in FETCH
//   imem_data    instruction word
//   op_sel       ALU op select, 000 except in EXEC
//   rd, rs       destination/source register index, straight from IR
//   reg_we       register-file write enable, high for the WB cycle
//   pc           current program counter
//   halted       high while in HALT
//   busy         high in FETCH, DECODE, EXEC and WB
module instr_sequencer #(
    parameter int unsigned           ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [7:0]        imem_data,
    output logic [2:0]        op_sel,
    output logic [1:0]        rd,
    output logic [1:0]        rs,
    output logic              reg_we,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        ir_q, ir_d;
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle, StHalt: begin
                // HALT resumes at pc, which already points past the halt word.
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (ir_q[7:5] != 3'b000) state_d = StExec;
                else if (ir_q[4])        state_d = StHalt;
                else                     state_d = StFetch;
            end
            StExec:  state_d = StWb;
            StWb:    state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ir_q      <= 8'h00;
            pc_q      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            op_sel    <= 3'b000;
            reg_we    <= 1'b0;
            halted    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            pc_q      <= pc_d;
            imem_req  <= (state_d == StFetch);
            imem_addr <= (state_d == StFetch) ? pc_d : '0;
            op_sel    <= (state_d == StExec) ? ir_d[7:5] : 3'b000;
            reg_we    <= (state_d == StWb);
            halted    <= (state_d == StHalt);
            busy      <= (state_d inside {StFetch, StDecode, StExec, StWb});
        end
    end

    assign rd = ir_q[3:2];
    assign rs = ir_q[1:0];
    assign pc = pc_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, imem_valid;
    logic [7:0] imem_data;
    logic       imem_req, reg_we, halted, busy;
    logic [7:0] imem_addr, pc;
    logic [2:0] op_sel;
    logic [1:0] rd, rs;

    // Second instance with RESET_PC at the top of the address space.
    logic       start2, imem_valid2;
    logic [7:0] imem_data2;
    logic       imem_req2, reg_we2, halted2, busy2;
    logic [7:0] imem_addr2, pc2;
    logic [2:0] op_sel2;
    logic [1:0] rd2, rs2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] word;
        int         waits;
        bit         poke;
        logic [2:0] exp_op;
        logic [1:0] exp_rd;
        logic [1:0] exp_rs;
        bit         exp_halt;
    } vec_t;

    vec_t       vecs[8];
    logic [6:0] sb[$];
    logic [7:0] m_pc;
    logic [3:0] m_rdrs;
    bit         m_halted;
    bit         prev_exec;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
        .op_sel(op_sel), .rd(rd), .rs(rs), .reg_we(reg_we), .pc(pc),
        .halted(halted), .busy(busy)
    );

    instr_sequencer #(.ADDR_W(8), .RESET_PC(8'hFF)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .imem_req(imem_req2),
        .imem_addr(imem_addr2), .imem_valid(imem_valid2), .imem_data(imem_data2),
        .op_sel(op_sel2), .rd(rd2), .rs(rs2), .reg_we(reg_we2), .pc(pc2),
        .halted(halted2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every non-zero op_sel must match the oldest fetched ALU word,
    // and reg_we must follow an EXEC cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_exec <= 1'b0;
        end else begin
            if (op_sel != 3'b000) begin
                if (sb.size() == 0) chk("sb_unexpected_exec", {29'd0, op_sel}, 32'd0);
                else chk("sb_exec_op_rd_rs", {25'd0, op_sel, rd, rs}, {25'd0, sb.pop_front()});
            end
            if (reg_we) chk("sb_we_after_exec", {31'd0, prev_exec}, 32'd1);
            prev_exec <= (op_sel != 3'b000);
        end
    end

    task automatic run_word(input vec_t v);
        int n = 0;
        if (m_halted) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            m_halted = 1'b0;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 20);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        for (int i = 0; i < v.waits; i++) begin
            imem_data = 8'hE7 ^ 8'(i);
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", {24'd0, imem_addr}, {24'd0, m_pc});
            chk("wait_ir_held", {28'd0, rd, rs}, {28'd0, m_rdrs});
        end
        imem_valid = 1'b1;
        imem_data  = v.word;
        if (v.exp_op != 3'b000) sb.push_back({v.exp_op, v.exp_rd, v.exp_rs});
        m_pc   = m_pc + 8'd1;
        m_rdrs = {v.exp_rd, v.exp_rs};
        @(posedge clk); #1;
        imem_valid = 1'b0;
        imem_data  = 8'h5A;
        // DECODE
        @(negedge clk);
        chk("dec_busy", {31'd0, busy}, 32'd1);
        chk("dec_opsel", {29'd0, op_sel}, 32'd0);
        chk("dec_req", {31'd0, imem_req}, 32'd0);
        chk("dec_pc", {24'd0, pc}, {24'd0, m_pc});
        chk("dec_rd_rs", {28'd0, rd, rs}, {28'd0, m_rdrs});
        if (v.poke) begin
            imem_valid = 1'b1;
            imem_data  = 8'h3C;
        end
        @(posedge clk); #1;
        imem_valid = 1'b0;
        imem_data  = 8'h5A;
        if (v.exp_op != 3'b000) begin
            @(negedge clk);
            chk("exec_opsel", {29'd0, op_sel}, {29'd0, v.exp_op});
            chk("exec_rd_rs", {28'd0, rd, rs}, {28'd0, m_rdrs});
            chk("exec_pc", {24'd0, pc}, {24'd0, m_pc});
            chk("exec_we", {31'd0, reg_we}, 32'd0);
            if (v.poke) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("wb_we", {31'd0, reg_we}, 32'd1);
            chk("wb_opsel", {29'd0, op_sel}, 32'd0);
            chk("wb_rd_rs", {28'd0, rd, rs}, {28'd0, m_rdrs});
            chk("wb_pc", {24'd0, pc}, {24'd0, m_pc});
        end else if (v.exp_halt) begin
            @(negedge clk);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_busy", {31'd0, busy}, 32'd0);
            chk("halt_pc", {24'd0, pc}, {24'd0, m_pc});
            m_halted = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; imem_valid = 1'b0; imem_data = 8'h00;
        start2 = 1'b0; imem_valid2 = 1'b0; imem_data2 = 8'h00;
        m_pc = 8'h00; m_rdrs = 4'h0; m_halted = 1'b0;

        //          word          waits poke op    rd     rs     halt
        vecs[0] = '{8'b101_0_11_01, 0, 0, 3'd5, 2'd3, 2'd1, 0};
        vecs[1] = '{8'b011_1_10_10, 3, 0, 3'd3, 2'd2, 2'd2, 0};
        vecs[2] = '{8'b110_0_01_11, 0, 1, 3'd6, 2'd1, 2'd3, 0};
        vecs[3] = '{8'h00,          1, 0, 3'd0, 2'd0, 2'd0, 0};
        vecs[4] = '{8'h10,          0, 0, 3'd0, 2'd0, 2'd0, 1};
        vecs[5] = '{8'b001_0_00_10, 1, 0, 3'd1, 2'd0, 2'd2, 0};
        vecs[6] = '{8'b111_0_10_01, 0, 1, 3'd7, 2'd2, 2'd1, 0};
        vecs[7] = '{8'h1F,          0, 0, 3'd0, 2'd3, 2'd3, 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_opsel", {29'd0, op_sel}, 32'd0);
        chk("rst_we", {31'd0, reg_we}, 32'd0);
        chk("rst_busy_halt", {30'd0, busy, halted}, 32'd0);
        chk("rst_rd_rs", {28'd0, rd, rs}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_pc2", {24'd0, pc2}, 32'hFF);
        @(posedge clk); #1 rst_n = 1'b1;

        // Table-driven program from reset
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        foreach (vecs[i]) run_word(vecs[i]);

        // Reset in the middle of EXEC
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("rx_fetch_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        imem_valid = 1'b1;
        imem_data  = 8'b010_0_01_10;
        sb.push_back({3'd2, 2'd1, 2'd2});
        @(posedge clk); #1 imem_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rx_exec_opsel", {29'd0, op_sel}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rx_opsel", {29'd0, op_sel}, 32'd0);
        chk("rx_we", {31'd0, reg_we}, 32'd0);
        chk("rx_pc", {24'd0, pc}, 32'd0);
        chk("rx_busy", {31'd0, busy}, 32'd0);
        chk("rx_rd_rs", {28'd0, rd, rs}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_pc = 8'h00; m_rdrs = 4'h0; m_halted = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rx_idle_busy", {31'd0, busy}, 32'd0);
            chk("rx_idle_req", {31'd0, imem_req}, 32'd0);
        end

        // start and imem_valid together in IDLE: only start acts
        start = 1'b1; imem_valid = 1'b1; imem_data = 8'hFF;
        @(posedge clk); #1 start = 1'b0; imem_valid = 1'b0;
        @(negedge clk);
        chk("sim_req", {31'd0, imem_req}, 32'd1);
        chk("sim_rd_rs", {28'd0, rd, rs}, 32'd0);
        chk("sim_pc", {24'd0, pc}, 32'd0);

        // NOP then HALT, then resume at address 2
        run_word('{8'h00, 0, 0, 3'd0, 2'd0, 2'd0, 0});
        run_word('{8'h10, 0, 0, 3'd0, 2'd0, 2'd0, 1});
        chk("halt_pc_two", {24'd0, pc}, 32'd2);
        run_word('{8'b100_0_00_11, 0, 0, 3'd4, 2'd0, 2'd3, 0});

        // PC wrap on the RESET_PC=FF instance
        @(negedge clk);
        chk("wrap_pc_rst", {24'd0, pc2}, 32'hFF);
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        @(negedge clk);
        chk("wrap_req", {31'd0, imem_req2}, 32'd1);
        chk("wrap_addr", {24'd0, imem_addr2}, 32'hFF);
        imem_valid2 = 1'b1;
        imem_data2  = 8'b011_0_10_00;
        @(posedge clk); #1 imem_valid2 = 1'b0;
        @(negedge clk);
        chk("wrap_pc", {24'd0, pc2}, 32'h00);
        @(negedge clk);
        chk("wrap_opsel", {29'd0, op_sel2}, 32'd3);
        chk("wrap_rd_rs", {28'd0, rd2, rs2}, 32'h8);
        @(negedge clk);
        chk("wrap_we", {31'd0, reg_we2}, 32'd1);
        @(negedge clk);
        chk("wrap_next_addr", {24'd0, imem_addr2}, 32'h00);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
